// File: rtl/onewire_read_slot_gen.sv
// -----------------------------------------------------------------------------
// onewire_read_slot_gen
//
// Master-side 1-Wire read-slot sequencer. On an accepted start it runs N
// consecutive read time slots on the open-drain DQ line. Each slot has a short
// low pulse, a sample point and a released-bus recovery gap. The slave's answer
// in each slot is delivered LSB first as one bit_value/bit_valid strobe, and a
// done pulse follows the last slot. All timing is counted in clk ticks.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   start      transaction request, accepted only while idle
//   num_bits   bits to read, captured on acceptance (clamped to MAX_BITS)
//   abort      synchronous cancel of a running transaction
//   dq_in      raw DQ pin value, asynchronous to clk
//   dq_oe      1 = pull DQ low, 0 = release (registered)
//   bit_value  most recently sampled bit, held between strobes
//   bit_valid  one-cycle strobe, bit_value/bit_index are new this cycle
//   bit_index  0-based index of the bit being strobed
//   busy       transaction in progress
//   done       one-cycle completion pulse
// -----------------------------------------------------------------------------
module onewire_read_slot_gen #(
    parameter int MAX_BITS = 16,
    parameter int T_LOW    = 150,
    parameter int T_SAMPLE = 650,
    parameter int T_SLOT   = 3500,
    parameter int T_REC    = 250
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [$clog2(MAX_BITS):0]   num_bits,
    input  logic                        abort,
    input  logic                        dq_in,
    output logic                        dq_oe,
    output logic                        bit_value,
    output logic                        bit_valid,
    output logic [$clog2(MAX_BITS)-1:0] bit_index,
    output logic                        busy,
    output logic                        done
);

    localparam int IW      = $clog2(MAX_BITS);
    localparam int NW      = IW + 1;
    localparam int CNT_MAX = (T_SLOT > T_REC) ? T_SLOT : T_REC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [NW-1:0] MAX_N     = NW'(MAX_BITS);
    localparam logic [CW-1:0] LOW_LAST  = CW'(T_LOW - 1);
    localparam logic [CW-1:0] SAMP_LAST = CW'(T_SAMPLE - 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(T_SLOT - 1);
    localparam logic [CW-1:0] REC_LAST  = CW'(T_REC - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SLOT    = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    // Illegal timing would make the slot sequence meaningless, so refuse to build.
    if (!(T_LOW >= 1 && T_LOW < T_SAMPLE && T_SAMPLE < T_SLOT && T_REC >= 1 &&
          MAX_BITS >= 2)) begin : g_param_check
        $error("onewire_read_slot_gen: illegal timing or MAX_BITS parameters");
    end

    logic          sync1_q, sync2_q;
    logic [1:0]    state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [NW-1:0] nbits_q,     nbits_d;
    logic [NW-1:0] bitcnt_q,    bitcnt_d;
    logic [NW-1:0] bitcnt_inc;
    logic          dq_oe_q,     dq_oe_d;
    logic          bit_value_q, bit_value_d;
    logic          bit_valid_q, bit_valid_d;
    logic [IW-1:0] bit_index_q, bit_index_d;
    logic          done_q,      done_d;

    // Two-flop synchronizer for the asynchronous pin. Reset to 1 because an
    // idle 1-Wire bus floats high through its pull-up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make both flops capture pre-edge
            // values, giving two real stages; blocking ones would collapse the
            // chain into a single flop.
            sync1_q <= dq_in;
            sync2_q <= sync1_q;
        end
    end

    assign bitcnt_inc = bitcnt_q + 1'b1;

    always_comb begin
        // NOTE: every _d signal gets a hold or default value up front, so no
        // branch can leave one unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        nbits_d     = nbits_q;
        bitcnt_d    = bitcnt_q;
        dq_oe_d     = dq_oe_q;
        bit_value_d = bit_value_q;
        bit_index_d = bit_index_q;
        bit_valid_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                dq_oe_d = 1'b0;
                // abort outranks a simultaneous start.
                if (start && !abort) begin
                    if (num_bits == '0) begin
                        done_d = 1'b1;
                    end else begin
                        nbits_d  = (num_bits > MAX_N) ? MAX_N : num_bits;
                        bitcnt_d = '0;
                        state_d  = ST_SLOT;
                        dq_oe_d  = 1'b1;
                    end
                end
            end

            ST_SLOT: begin
                if (abort) begin
                    // Any sample due this cycle is dropped with the transaction.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    dq_oe_d = 1'b0;
                end else begin
                    if (cnt_q == SAMP_LAST) begin
                        bit_value_d = sync2_q;
                        bit_index_d = bitcnt_q[IW-1:0];
                        bit_valid_d = 1'b1;
                    end
                    if (cnt_q == SLOT_LAST) begin
                        state_d = ST_RECOVER;
                        cnt_d   = '0;
                        dq_oe_d = 1'b0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        // dq_oe is registered: look one count ahead so it is
                        // high exactly while cnt < T_LOW.
                        dq_oe_d = (cnt_q < LOW_LAST);
                    end
                end
            end

            ST_RECOVER: begin
                dq_oe_d = 1'b0;
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REC_LAST) begin
                    cnt_d    = '0;
                    bitcnt_d = bitcnt_inc;
                    if (bitcnt_inc < nbits_q) begin
                        state_d = ST_SLOT;
                        dq_oe_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                dq_oe_d = 1'b0;
            end
        endcase
    end

    // Asynchronous reset releases the bus immediately, even mid low-phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            nbits_q     <= '0;
            bitcnt_q    <= '0;
            dq_oe_q     <= 1'b0;
            bit_value_q <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_index_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nbits_q     <= nbits_d;
            bitcnt_q    <= bitcnt_d;
            dq_oe_q     <= dq_oe_d;
            bit_value_q <= bit_value_d;
            bit_valid_q <= bit_valid_d;
            bit_index_q <= bit_index_d;
            done_q      <= done_d;
        end
    end

    assign dq_oe     = dq_oe_q;
    assign bit_value = bit_value_q;
    assign bit_valid = bit_valid_q;
    assign bit_index = bit_index_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_onewire_read_slot_gen.sv
// -----------------------------------------------------------------------------
// tb_onewire_read_slot_gen
//
// Bench for onewire_read_slot_gen with short slot timing. A per-cycle model
// derives every output from the transaction start cycle, the clamped bit count,
// the slot period and the recorded dq_in history. Directed sequences pin
// hand-computed cycle numbers, then a randomized phase exercises starts,
// aborts, resets and slave data.
// -----------------------------------------------------------------------------
module tb_onewire_read_slot_gen;

    localparam int MAX_BITS = 16;
    localparam int T_LOW    = 2;
    localparam int T_SAMPLE = 5;
    localparam int T_SLOT   = 10;
    localparam int T_REC    = 3;
    localparam int P        = T_SLOT + T_REC;
    localparam int IW       = $clog2(MAX_BITS);
    localparam int NW       = IW + 1;
    localparam int HMAX     = 64;

    typedef logic [NW-1:0] nb_t;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          start    = 1'b0;
    logic          abort    = 1'b0;
    logic          dq_in    = 1'b1;
    nb_t           num_bits = '0;
    logic          dq_oe, bit_value, bit_valid, busy, done;
    logic [IW-1:0] bit_index;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    onewire_read_slot_gen #(
        .MAX_BITS (MAX_BITS),
        .T_LOW    (T_LOW),
        .T_SAMPLE (T_SAMPLE),
        .T_SLOT   (T_SLOT),
        .T_REC    (T_REC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_bits  (num_bits),
        .abort     (abort),
        .dq_in     (dq_in),
        .dq_oe     (dq_oe),
        .bit_value (bit_value),
        .bit_valid (bit_valid),
        .bit_index (bit_index),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------- model
    // A transaction is described by its acceptance cycle, its clamped length
    // and the first cycle at which it no longer exists (normal end or abort).
    bit            m_active  = 1'b0;
    bit            m_aborted = 1'b0;
    int            m_c0      = 0;
    int            m_n       = 0;
    int            m_end     = 0;
    logic          m_bv      = 1'b0;
    logic [IW-1:0] m_bi      = '0;
    bit            hist [HMAX];

    always @(negedge clk) begin : cmp
        int r;
        bit busy_e, oe_e, valid_e, done_e;
        hist[cyc % HMAX] = dq_in;
        if (rst) begin
            m_active = 1'b0;
            m_bv     = 1'b0;
            m_bi     = '0;
            check("cmp_rst_dq_oe",     dq_oe,     0);
            check("cmp_rst_busy",      busy,      0);
            check("cmp_rst_done",      done,      0);
            check("cmp_rst_bit_valid", bit_valid, 0);
            check("cmp_rst_bit_value", bit_value, 0);
            check("cmp_rst_bit_index", bit_index, 0);
        end else begin
            busy_e  = 1'b0;
            oe_e    = 1'b0;
            valid_e = 1'b0;
            done_e  = 1'b0;
            r       = 0;
            if (m_active) begin
                r = cyc - m_c0;
                if (r >= 1 && cyc < m_end) begin
                    busy_e  = 1'b1;
                    oe_e    = ((r - 1) % P) < T_LOW;
                    valid_e = ((r - 1) % P) == T_SAMPLE;
                end
                done_e = !m_aborted && (r == 1 + m_n * P);
            end
            if (valid_e) begin
                // Two synchronizer stages plus the output register: the bit
                // shown now is the pin value from three cycles earlier.
                m_bv = hist[(cyc - 3) % HMAX];
                m_bi = IW'((r - 1) / P);
            end
            check("cmp_dq_oe",     dq_oe,     oe_e);
            check("cmp_busy",      busy,      busy_e);
            check("cmp_bit_valid", bit_valid, valid_e);
            check("cmp_done",      done,      done_e);
            check("cmp_bit_value", bit_value, m_bv);
            check("cmp_bit_index", bit_index, m_bi);
            if (!busy_e && start && !abort) begin
                m_active  = 1'b1;
                m_aborted = 1'b0;
                m_c0      = cyc;
                m_n       = (int'(num_bits) > MAX_BITS) ? MAX_BITS : int'(num_bits);
                m_end     = cyc + 1 + m_n * P;
            end else if (busy_e && abort) begin
                m_end     = cyc + 1;
                m_aborted = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------- sequences
    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 1000) begin
            tick();
            k++;
        end
        check("wait_idle_in_time", (k < 1000), 1);
    endtask

    task automatic lit_two_bits();
        dq_in = 1'b1; num_bits = nb_t'(2); start = 1'b1;
        for (int r = 0; r <= 28; r++) begin
            @(negedge clk);
            check("two_dq_oe", dq_oe, (r == 1 || r == 2 || r == 14 || r == 15));
            check("two_valid", bit_valid, (r == 6 || r == 19));
            check("two_busy",  busy, (r >= 1 && r <= 26));
            check("two_done",  done, (r == 27));
            if (r == 6 || r == 19) begin
                check("two_value", bit_value, 1);
                check("two_index", bit_index, (r == 6) ? 0 : 1);
            end
            tick();
            start = 1'b0;
        end
    endtask

    task automatic lit_slave();
        logic [15:0] asm_bits;
        int nv, rn;
        dq_in = 1'b1; num_bits = nb_t'(4); start = 1'b1;
        asm_bits = '0; nv = 0;
        for (int r = 0; r <= 2 + 4 * P; r++) begin
            @(negedge clk);
            if (bit_valid) begin
                asm_bits[bit_index] = bit_value;
                nv++;
            end
            tick();
            start = 1'b0;
            rn = r + 1;
            dq_in = !((((rn - 1) / P) == 1 || ((rn - 1) / P) == 3) && ((rn - 1) % P) <= 8);
        end
        dq_in = 1'b1;
        check("slave_bits",  asm_bits, 16'h0005);
        check("slave_count", nv, 4);
    endtask

    task automatic lit_zero();
        num_bits = '0; start = 1'b1;
        for (int r = 0; r <= 3; r++) begin
            @(negedge clk);
            check("zero_dq_oe", dq_oe, 0);
            check("zero_busy",  busy, 0);
            check("zero_done",  done, (r == 1));
            tick();
            start = 1'b0;
        end
    endtask

    task automatic lit_clamp();
        int nv, k;
        bit seen;
        num_bits = nb_t'(MAX_BITS + 5); start = 1'b1;
        nv = 0; seen = 1'b0; k = 0;
        while (!seen && k < MAX_BITS * P + 10) begin
            @(negedge clk);
            if (bit_valid) nv++;
            if (done) seen = 1'b1;
            tick();
            start = 1'b0;
            k++;
        end
        check("clamp_done_seen", seen, 1);
        check("clamp_count", nv, MAX_BITS);
    endtask

    task automatic lit_abort();
        int nv, nd;
        num_bits = nb_t'(4); start = 1'b1; nv = 0; nd = 0;
        for (int r = 0; r <= 4 + 4 * P; r++) begin
            @(negedge clk);
            if (bit_valid) nv++;
            if (done) nd++;
            if (r == 17) check("abort_busy_before", busy, 1);
            if (r == 18) begin
                check("abort_dq_oe_after", dq_oe, 0);
                check("abort_busy_after",  busy, 0);
            end
            tick();
            start = 1'b0;
            abort = (r + 1 == 1 + P + 3);
        end
        abort = 1'b0;
        check("abort_valid_count", nv, 1);
        check("abort_no_done", nd, 0);
        num_bits = nb_t'(1); start = 1'b1;
        for (int r = 0; r <= 2 + P; r++) begin
            @(negedge clk);
            check("restart_busy",  busy,  (r >= 1 && r <= P));
            check("restart_dq_oe", dq_oe, (r >= 1 && r <= T_LOW));
            check("restart_done",  done,  (r == 1 + P));
            tick();
            start = 1'b0;
        end
    endtask

    task automatic lit_reset_mid();
        num_bits = nb_t'(3); start = 1'b1;
        for (int r = 0; r <= P; r++) begin
            @(negedge clk);
            tick();
            start = 1'b0;
        end
        @(negedge clk);
        check("rstmid_dq_oe_before", dq_oe, 1);
        #1 rst = 1'b1;
        #1;
        check("rstmid_dq_oe",     dq_oe,     0);
        check("rstmid_busy",      busy,      0);
        check("rstmid_done",      done,      0);
        check("rstmid_bit_valid", bit_valid, 0);
        check("rstmid_bit_value", bit_value, 0);
        check("rstmid_bit_index", bit_index, 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic lit_back_to_back();
        int nv, nd, rn;
        num_bits = nb_t'(2); start = 1'b1; nv = 0; nd = 0;
        for (int r = 0; r <= 43; r++) begin
            @(negedge clk);
            if (bit_valid) nv++;
            if (done) nd++;
            check("b2b_done", done, (r == 1 + 2 * P) || (r == 2 + 3 * P));
            if (r == 2 + 2 * P) begin
                check("b2b_dq_oe_next", dq_oe, 1);
                check("b2b_busy_next",  busy, 1);
            end
            tick();
            rn = r + 1;
            start    = (rn == 5 || rn == 12 || rn == 20 || rn == 1 + 2 * P);
            num_bits = (rn == 1 + 2 * P) ? nb_t'(1) : nb_t'(7);
        end
        start = 1'b0;
        check("b2b_valid_count", nv, 3);
        check("b2b_done_count",  nd, 2);
    endtask

    task automatic random_phase();
        for (int i = 0; i < 6000; i++) begin
            dq_in    = 1'($urandom_range(0, 1));
            abort    = ($urandom_range(0, 399) == 0);
            start    = ($urandom_range(0, 15) == 0);
            num_bits = nb_t'($urandom_range(0, MAX_BITS + 4));
            if ($urandom_range(0, 2999) == 0) begin
                rst   = 1'b1;
                start = 1'b0;
            end else begin
                rst = 1'b0;
            end
            tick();
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0; dq_in = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("reset_dq_oe",     dq_oe,     0);
        check("reset_busy",      busy,      0);
        check("reset_done",      done,      0);
        check("reset_bit_valid", bit_valid, 0);
        tick();
        rst = 1'b0;
        tick();
        lit_two_bits();
        wait_idle();
        lit_slave();
        wait_idle();
        lit_zero();
        lit_clamp();
        wait_idle();
        lit_abort();
        wait_idle();
        lit_reset_mid();
        lit_back_to_back();
        wait_idle();
        random_phase();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/onewire_read_slot_gen.md
Name: onewire_read_slot_gen

Overview:
- Master-side 1-Wire read-slot sequencer; sits directly upstream of the serial-to-parallel assembler.
- On a start request, generates N consecutive read time slots on the open-drain DQ line and samples the slave response in each slot.
- Emits one bit per slot, LSB first, as bit_value with a one-cycle bit_valid strobe, followed by a done pulse.
- All timing is in clk ticks via parameters.

Parameters:
- MAX_BITS, 16, maximum bits per transaction.
- T_LOW, 150, cycles DQ is driven low at slot start (3 us @ 50 MHz).
- T_SAMPLE, 650, cycle offset from slot start at which DQ is sampled (13 us).
- T_SLOT, 3500, total slot length in cycles (70 us).
- T_REC, 250, released-bus recovery cycles after each slot (5 us).
- Legality: 1 <= T_LOW < T_SAMPLE < T_SLOT, T_REC >= 1. A violation is an elaboration error.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only in IDLE.
- num_bits  in  $clog2(MAX_BITS)+1  bits to read; captured on acceptance.
- abort  in  1  synchronous cancel.
- dq_in  in  1  raw DQ pin value (asynchronous to clk).
- dq_oe  out  1  1 = pull DQ low, 0 = release; registered.
- bit_value  out  1  most recently sampled bit.
- bit_valid  out  1  one-cycle strobe; bit_value is new this cycle.
- bit_index  out  $clog2(MAX_BITS)  0-based index of the bit on bit_valid.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- **Reset values:** dq_oe=0, bit_value=0, bit_valid=0, bit_index=0, busy=0, done=0, state=IDLE, counters=0. dq_in synchronizer flops reset to 1.
  - Reset mid-slot releases the bus asynchronously; no done is issued.
- **Input synchronizer:** dq_in passes through a 2-flop synchronizer (dq_s). Only dq_s is used for sampling.
- **States:** IDLE, SLOT, RECOVER.
- **IDLE:**
  - start=1 and num_bits!=0: capture N=min(num_bits, MAX_BITS), bit counter=0.
  - Next cycle: SLOT with cnt=0, dq_oe=1, busy=1.
  - start=1 and num_bits==0: no slot; done=1 next cycle; busy stays 0.
- **SLOT:**
  - cnt increments each cycle.
  - dq_oe=1 while cnt < T_LOW, else 0. dq_oe is registered, so it is glitch-free.
  - At the edge ending the cycle with cnt==T_SAMPLE-1: bit_value<=dq_s, bit_index<=bit counter, bit_valid<=1 for exactly one cycle.
  - In the cycle with cnt==T_SLOT-1: go to RECOVER, cnt=0.
- **RECOVER:**
  - dq_oe=0 for T_REC cycles.
  - Then bit counter+1. If bit counter+1 < N: SLOT with cnt=0. Otherwise: IDLE with done=1 and busy=0 in the same cycle.
- **Slot period:** P = T_SLOT + T_REC cycles.
- **Cycle numbering:** the start-acceptance cycle is cycle 0.
  - Bit n's bit_valid is in cycle 1 + n*P + T_SAMPLE.
  - done is in cycle 1 + N*P.
- **Restart:** start in the done cycle (already IDLE) is accepted. start while busy is ignored; num_bits changes while busy have no effect.
- **abort:**
  - In SLOT or RECOVER: next cycle dq_oe=0, state IDLE, busy=0. No done and no further bit_valid.
  - A sample scheduled in the same cycle as abort is discarded.
  - abort in IDLE has no effect. abort and start together in IDLE: abort wins, start ignored.
- **bit_value persistence:** holds its value between strobes. The downstream stage must qualify on bit_valid.

Test Plan:
- **Two bits, bus high:** T_LOW=2, T_SAMPLE=5, T_SLOT=10, T_REC=3; start with num_bits=2, dq_in held 1.
  - dq_oe high in cycles 1-2 and 14-15.
  - bit_valid in cycles 6 and 19 with bit_value=1 and bit_index 0, 1.
  - done in cycle 27; busy high in cycles 1-26.
- **Slave pattern:** same params, num_bits=4; bench pulls dq_in low during slots 1 and 3 (cnt 0..8).
  - Bits delivered 0,1,0,1 → sampled 1,0,1,0 LSB-first, i.e. assembled 4'b0101.
  - Checks that the synchronizer delay stays within the sample window.
- **Zero and clamp:** num_bits=0 → done next cycle, dq_oe never asserted, busy stays 0.
  - num_bits=MAX_BITS+5 → exactly MAX_BITS bit_valid pulses.
- **Abort:** abort in slot 1 at cnt=3.
  - dq_oe=0 next cycle, busy=0, only one bit_valid total, no done.
  - A new start is then accepted normally.
- **Reset mid-low phase:** assert rst while dq_oe=1.
  - dq_oe drops without waiting for a clock edge; all outputs at reset values.
- **Start while busy / back-to-back:** start pulses while busy are ignored and the pulse count is unchanged.
  - start in the done cycle → second transaction's first dq_oe appears in the next cycle.
